// File: rtl/aes128_encrypt_core.sv
// ---------------------------------------------------------------------------
// aes128_encrypt_core -- iterative AES-128 encryption, one round per clock.
//
// Contains:
//   aes_sbox           combinational forward S-box (GF(2^8) inverse + affine)
//   aes_addroundkey    combinational state ^ round key
//   aes_key_expand_128 on-the-fly round-key generator, one step per clock
//   aes128_encrypt_core top level
//
// Top ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   ld        start strobe; key/text_in sampled on the edge where it is high
//   key       128-bit cipher key, [127:96] = w0
//   text_in   128-bit plaintext, [127:120] = s(0,0), column-major
//   done      one-cycle pulse, text_out valid from this cycle onward
//   text_out  128-bit ciphertext, same byte order as text_in
// ---------------------------------------------------------------------------

// Forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// Ports: a (input byte), d (substituted byte).
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] d
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // a^254 == a^-1 for nonzero a, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return (x == 8'h00) ? 8'h00 : r;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv = gf_inv(a);
    d   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

// Initial whitening: state = plaintext ^ raw key.
// Ports: text (128-bit data), round_key (128-bit key), result.
module aes_addroundkey (
  input  logic [127:0] text,
  input  logic [127:0] round_key,
  output logic [127:0] result
);
  assign result = text ^ round_key;
endmodule

// Round-key generator. Loads the cipher key on ld, otherwise advances one
// round key per clock; round_key always presents the current w0..w3.
// Ports: clk, rst, ld, key (cipher key), round_key (current key words).
module aes_key_expand_128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [127:0] key,
  output logic [127:0] round_key
);
  logic [31:0] w0_reg, w1_reg, w2_reg, w3_reg;
  logic [3:0]  rcon_idx_reg;
  logic [31:0] rot_word;
  logic [31:0] sub_word;
  logic [31:0] w0_next, w1_next, w2_next, w3_next;
  logic [7:0]  rcon;

  always_comb begin
    case (rcon_idx_reg)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign rot_word = {w3_reg[23:0], w3_reg[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .a(rot_word[8*gi +: 8]),
        .d(sub_word[8*gi +: 8])
      );
    end
  endgenerate

  assign w0_next = w0_reg ^ sub_word ^ {rcon, 24'h000000};
  assign w1_next = w1_reg ^ w0_next;
  assign w2_next = w2_reg ^ w1_next;
  assign w3_next = w3_reg ^ w2_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w0_reg       <= 32'h0;
      w1_reg       <= 32'h0;
      w2_reg       <= 32'h0;
      w3_reg       <= 32'h0;
      rcon_idx_reg <= 4'd0;
    end else if (ld) begin
      w0_reg       <= key[127:96];
      w1_reg       <= key[95:64];
      w2_reg       <= key[63:32];
      w3_reg       <= key[31:0];
      rcon_idx_reg <= 4'd0;
    end else begin
      // Keeps stepping when idle; the index wraps so idle stepping is harmless.
      w0_reg       <= w0_next;
      w1_reg       <= w1_next;
      w2_reg       <= w2_next;
      w3_reg       <= w3_next;
      rcon_idx_reg <= (rcon_idx_reg == 4'd9) ? 4'd0 : rcon_idx_reg + 4'd1;
    end
  end

  assign round_key = {w0_reg, w1_reg, w2_reg, w3_reg};
endmodule

module aes128_encrypt_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic         done,
  output logic [127:0] text_out
);
  logic [127:0] text_in_r;
  logic         ld_r;
  logic [3:0]   dcnt;
  logic [127:0] state_reg;
  logic [127:0] round_key;
  logic [127:0] ark_out;
  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  aes_key_expand_128 u_key (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .key      (key),
    .round_key(round_key)
  );

  aes_addroundkey u_ark (
    .text     (text_in_r),
    .round_key(round_key),
    .result   (ark_out)
  );

  // Byte k of the 128-bit word lives at [127-8k -: 8] and is s(k%4, k/4).
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bytes
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;

      aes_sbox u_sbox (
        .a(state_reg[127-8*gi -: 8]),
        .d(sb[127-8*gi -: 8])
      );

      // ShiftRows: s'(r,c) = s(r, (c+r) mod 4)
      assign sr[127-8*gi -: 8] = sb[127-8*SRC -: 8];
    end

    for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr[127-32*gi      -: 8];
      assign a1 = sr[127-32*gi-8    -: 8];
      assign a2 = sr[127-32*gi-16   -: 8];
      assign a3 = sr[127-32*gi-24   -: 8];
      assign mc[127-32*gi    -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc[127-32*gi-8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc[127-32*gi-16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc[127-32*gi-24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

  // dcnt == 11 right after ld; 10..2 during rounds 1..9; 1 on the final round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      text_in_r <= 128'h0;
      ld_r      <= 1'b0;
      dcnt      <= 4'd0;
      state_reg <= 128'h0;
      done      <= 1'b0;
      text_out  <= 128'h0;
    end else begin
      ld_r <= ld;
      done <= (dcnt == 4'd1) && !ld;

      if (ld) begin
        text_in_r <= text_in;
        dcnt      <= 4'd11;
      end else if (dcnt != 4'd0) begin
        dcnt <= dcnt - 4'd1;
      end

      if (ld_r) begin
        state_reg <= ark_out;
      end else if (dcnt != 4'd0) begin
        state_reg <= mc ^ round_key;
      end

      // Final round skips MixColumns and lands directly in text_out.
      if ((dcnt == 4'd1) && !ld) begin
        text_out <= sr ^ round_key;
      end
    end
  end
endmodule

// File: tb/tb_aes128_encrypt_core.sv
module tb_aes128_encrypt_core;
  logic         clk;
  logic         rst;
  logic         ld;
  logic [127:0] key;
  logic [127:0] text_in;
  logic         done;
  logic [127:0] text_out;

  logic [7:0]   sb_a;
  logic [7:0]   sb_d;

  aes128_encrypt_core dut (
    .clk     (clk),
    .rst     (rst),
    .ld      (ld),
    .key     (key),
    .text_in (text_in),
    .done    (done),
    .text_out(text_out)
  );

  aes_sbox u_sbox_chk (
    .a(sb_a),
    .d(sb_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  typedef struct {
    logic [127:0] ct;
    int           due;
  } exp_t;

  vec_t vecs[3];
  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Caller must be at a negedge. Drives ld for one cycle, scrambles inputs
  // afterwards, and replaces any in-flight expectation (restart semantics).
  task automatic start_block(input logic [127:0] k, input logic [127:0] p, input logic [127:0] c);
    exp_t e;
    ld      = 1'b1;
    key     = k;
    text_in = p;
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    e.ct  = c;
    e.due = cyc + 12;
    exp_q.push_back(e);
    $display("ld  cycle %0d key=%h pt=%h expect=%h", cyc, k, p, c);
    @(negedge clk);
    ld      = 1'b0;
    key     = {$urandom, $urandom, $urandom, $urandom};
    text_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no done, expected one within 40 cycles");
      exp_q.delete();
    end
  endtask

  // Scoreboard monitor: every done must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          $display("done cycle %0d text_out=%h", cyc, text_out);
          check("text_out", text_out, e.ct);
          check("done_cycle", 128'(cyc), 128'(e.due));
        end
      end
    end
  end

  initial begin
    logic [7:0]   sb_in[5];
    logic [7:0]   sb_exp[5];
    logic [127:0] hold_val;
    int           n;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{128'h0, 128'h0,
                128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    sb_in  = '{8'h00, 8'h53, 8'hff, 8'h01, 8'h10};
    sb_exp = '{8'h63, 8'hed, 8'h16, 8'h7c, 8'hca};

    rst = 1'b1; ld = 1'b0; key = '0; text_in = '0; sb_a = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_done", 128'(done), 128'(1'b0));
    check("reset_text_out", text_out, 128'h0);
    rst = 1'b0;
    @(negedge clk);

    // S-box spot values
    for (int i = 0; i < 5; i++) begin
      sb_a = sb_in[i];
      #1;
      $display("sbox a=%h d=%h", sb_a, sb_d);
      check("sbox", 128'(sb_d), 128'(sb_exp[i]));
    end

    // Table-driven known-answer vectors
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start_block(vecs[i].key, vecs[i].pt, vecs[i].ct);
      wait_idle();
    end

    // Hold: text_out stays for 20 cycles after the all-zero block, no new done
    hold_val = vecs[2].ct;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("text_out_hold", text_out, hold_val);
    end

    // Round-1 key for the App. B key
    @(negedge clk);
    start_block(vecs[1].key, vecs[1].pt, vecs[1].ct);
    @(posedge clk);
    #1;
    check("round1_key", dut.round_key, 128'ha0fafe1788542cb123a339392a6c7605);
    wait_idle();

    // Restart mid-block: second ld 5 cycles after the first
    @(negedge clk);
    start_block(vecs[0].key, vecs[0].pt, vecs[0].ct);
    repeat (4) @(negedge clk);
    start_block(vecs[1].key, vecs[1].pt, vecs[1].ct);
    wait_idle();

    // Reset mid-block: no done, text_out cleared, then a normal block
    @(negedge clk);
    start_block(vecs[0].key, vecs[0].pt, vecs[0].ct);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("rst_text_out", text_out, 128'h0);
    start_block(vecs[2].key, vecs[2].pt, vecs[2].ct);
    wait_idle();

    // Back-to-back: next ld issued during the done cycle
    @(negedge clk);
    start_block(vecs[0].key, vecs[0].pt, vecs[0].ct);
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done", 128'(done), 128'(1'b1));
    start_block(vecs[1].key, vecs[1].pt, vecs[1].ct);
    wait_idle();

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
